sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4: word length in bits, legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in out[WIDTH-1]; 0 = first received bit lands in out[0].
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  bit strobe; `in` is sampled only on edges where en=1.
REQ-006 in  input  1  serial data bit.
REQ-007 flush  input  1  discards any partially assembled word.
REQ-008 ack  input  1  consumer accepts the word currently presented on out.
REQ-009 out  output  WIDTH  last completed word, registered.
REQ-010 valid  output  1  level; high while out holds an unacknowledged word.
REQ-011 overrun  output  1  sticky; a completed word overwrote an unacknowledged one.
REQ-012 busy  output  1  high while a partial word is in progress, registered-state decode.

Function
REQ-013 Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH-1), two-state FSM IDLE (cnt=0) / SHIFT (0<cnt<WIDTH).
REQ-014 IDLE + en=1 with WIDTH>1: the block captures the bit, sets cnt=1 and enters SHIFT; with WIDTH=1 the word completes immediately.
REQ-015 SHIFT + en=1 with cnt<WIDTH-1: the block shifts in the bit and increments cnt.
REQ-016 Shift rule for MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in}.
REQ-017 Shift rule for MSB_FIRST=0: sr <= {in, sr[WIDTH-1:1]}.
REQ-018 On en=1 with cnt=WIDTH-1 (word completion), the same edge SHALL load out with the fully assembled word including the current bit, set valid=1, clear cnt and sr, and return to IDLE.
REQ-019 Latency: out and valid update on the edge that samples the WIDTH-th bit; there are zero additional cycles.
REQ-020 When en=0 and flush=0, sr, cnt and the FSM state SHALL hold; gaps between bits of any length are legal.
REQ-021 valid clears on the edge where ack=1 and valid=1; ack with valid=0 is ignored; out retains its value after ack.
REQ-022 Completion and ack in the same cycle: the new word is loaded, valid stays 1 and overrun is unchanged.
REQ-023 Completion while valid=1 and ack=0: out is overwritten with the new word, valid stays 1 and overrun is set to 1.
REQ-024 overrun SHALL clear only on reset.
REQ-025 flush=1 SHALL clear sr and cnt and force IDLE, with priority over en in the same cycle (that bit is discarded).
REQ-026 flush SHALL NOT alter out, valid or overrun.
REQ-027 busy = 1 exactly when the FSM is in SHIFT.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force: out=0, valid=0, overrun=0, busy=0, cnt=0, sr=0, FSM=IDLE.
REQ-029 Reset mid-word SHALL discard the partial bits; the first en=1 after deassertion is bit 0 of a new word.
REQ-030 While rst=1, en, in, flush and ack are ignored.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-031 Basic: reset, then en=1 for 4 consecutive cycles with in=1,0,0,1 -> after the 4th edge out=4'b1001 and valid=1; busy=1 after edges 1-3 and busy=0 after edge 4.
REQ-032 Ack: hold ack=0 for 3 cycles, then ack=1 for 1 cycle -> valid=1 throughout the wait and valid=0 after the ack edge; out stays 4'b1001.
REQ-033 Overrun: deliver 4'b1001 with no ack, then 0,1,1,0 -> out=4'b0110, valid=1, overrun=1; repeat with ack asserted on the completing edge -> overrun=0.
REQ-034 Flush and gaps: send 1,1, then flush=1 together with en=1, then send 1,0,1,1 with en=0 idle cycles between bits -> out=4'b1011 and no earlier bits are present.
REQ-035 Async reset: assert rst between clock edges after 2 bits with valid=1 -> busy, valid, out and overrun become 0 before the next edge; the next 4 bits 1,1,0,0 give out=4'b1100.
REQ-036 MSB_FIRST=0: send in=1,0,0,0 -> out=4'b0001; loopback from a 4-bit parallel-in serial-out source loaded with 4'b1001 shall reproduce 4'b1001 when the bit orders match.

Source files
------------

// File: rtl/sipo_rx_if.sv
// Serial-in handshake bundle: bit strobe/data/flush/ack in, assembled word and status out.
interface sipo_rx_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             in;
  logic             flush;
  logic             ack;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             overrun;
  logic             busy;

  // Producer/consumer side: drives the serial stream and ack, observes the word.
  modport master (
    output en, in, flush, ack,
    input  out, valid, overrun, busy
  );

  // Receiver side.
  modport slave (
    input  en, in, flush, ack,
    output out, valid, overrun, busy
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH bits per word, presents it
// with a valid/ack handshake and a sticky overrun flag.
module sipo_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  sipo_rx_if.slave  bus
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted_c;
  logic             done_c;

  // Word completes when the last bit position is strobed and no flush overrides it.
  assign done_c = bus.en & ~bus.flush & (cnt_q == LAST);

  // Shift register with the current bit inserted; whole-vector shifts keep WIDTH=1 legal.
  assign shifted_c = MSB_FIRST ? ((sr_q << 1) | WIDTH'(bus.in))
                               : ((sr_q >> 1) | (WIDTH'(bus.in) << (WIDTH - 1)));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: flush wins, otherwise a strobe either starts/continues or ends a word.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (bus.en) begin
      state_d = done_c ? IDLE : SHIFT;
    end
  end

  // Datapath and handshake next values.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (bus.ack && valid_q) begin
      valid_d = 1'b0;
    end
    if (bus.flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (done_c) begin
      out_d     = shifted_c;
      valid_d   = 1'b1;
      overrun_d = overrun_q | (valid_q & ~bus.ack);
      sr_d      = '0;
      cnt_d     = '0;
    end else if (bus.en) begin
      sr_d  = shifted_c;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: vector table plus hand sequences, with a word scoreboard.
module tb_sipo_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sipo_rx_if #(.WIDTH(4)) bus ();
  sipo_rx_if #(.WIDTH(4)) bus2 ();

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       in;
    logic       flush;
    logic       ack;
    logic [3:0] out;
    logic       valid;
    logic       busy;
    logic       ovr;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sbq[$];
  int         npass  = 0;
  int         ntotal = 0;
  int         mcnt   = 0;
  logic [3:0] mword  = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic e, input logic i, input logic f, input logic a,
                     input logic [3:0] o, input logic v, input logic b, input logic ov);
    vec_t t;
    t.rst = r; t.en = e; t.in = i; t.flush = f; t.ack = a;
    t.out = o; t.valid = v; t.busy = b; t.ovr = ov;
    vecs.push_back(t);
  endtask

  // Reference model of the MSB-first receiver: bit k of a word lands at index 3-k.
  task automatic model_step(input logic r, input logic e, input logic i, input logic f);
    if (r) begin
      mcnt = 0; mword = 4'b0000; sbq.delete();
    end else if (f) begin
      mcnt = 0; mword = 4'b0000;
    end else if (e) begin
      mword[3-mcnt] = i;
      mcnt++;
      if (mcnt == 4) begin
        sbq.push_back(mword);
        mcnt = 0; mword = 4'b0000;
      end
    end
  endtask

  // Pop and compare any word the model says completed on the edge just taken.
  task automatic sb_check();
    logic [3:0] e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("sb_word", 32'(bus.out), 32'(e));
      check("sb_valid", 32'(bus.valid), 32'd1);
    end
  endtask

  task automatic send(input logic b);
    bus.en = 1'b1; bus.in = b;
    model_step(1'b0, 1'b1, b, 1'b0);
    @(posedge clk); #1;
    bus.en = 1'b0; bus.in = 1'b0;
    sb_check();
  endtask

  task automatic send2(input logic b);
    bus2.en = 1'b1; bus2.in = b;
    @(posedge clk); #1;
    bus2.en = 1'b0; bus2.in = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t       v;
    logic [3:0] p;
    bus.en = 1'b0;  bus.in = 1'b0;  bus.flush = 1'b0;  bus.ack = 1'b0;
    bus2.en = 1'b0; bus2.in = 1'b0; bus2.flush = 1'b0; bus2.ack = 1'b0;

    // rst en in fl ack | out valid busy ovr
    add(0,1,1,0,0, 4'h0,0,1,0); add(0,1,0,0,0, 4'h0,0,1,0);
    add(0,1,0,0,0, 4'h0,0,1,0); add(0,1,1,0,0, 4'h9,1,0,0);
    add(0,0,0,0,0, 4'h9,1,0,0); add(0,0,0,0,0, 4'h9,1,0,0);
    add(0,0,0,0,0, 4'h9,1,0,0); add(0,0,0,0,1, 4'h9,0,0,0);
    add(0,1,1,0,0, 4'h9,0,1,0); add(0,1,0,0,0, 4'h9,0,1,0);
    add(0,1,0,0,0, 4'h9,0,1,0); add(0,1,1,0,0, 4'h9,1,0,0);
    add(0,1,0,0,0, 4'h9,1,1,0); add(0,1,1,0,0, 4'h9,1,1,0);
    add(0,1,1,0,0, 4'h9,1,1,0); add(0,1,0,0,0, 4'h6,1,0,1);
    add(1,1,1,1,1, 4'h0,0,0,0);
    add(0,1,1,0,0, 4'h0,0,1,0); add(0,1,0,0,0, 4'h0,0,1,0);
    add(0,1,0,0,0, 4'h0,0,1,0); add(0,1,1,0,0, 4'h9,1,0,0);
    add(0,1,0,0,0, 4'h9,1,1,0); add(0,1,1,0,0, 4'h9,1,1,0);
    add(0,1,1,0,0, 4'h9,1,1,0); add(0,1,0,0,1, 4'h6,1,0,0);
    add(0,0,0,0,1, 4'h6,0,0,0); add(0,0,0,0,1, 4'h6,0,0,0);
    add(0,1,1,0,0, 4'h6,0,1,0); add(0,1,1,0,0, 4'h6,0,1,0);
    add(0,1,1,1,0, 4'h6,0,0,0); add(0,1,1,0,0, 4'h6,0,1,0);
    add(0,0,0,0,0, 4'h6,0,1,0); add(0,1,0,0,0, 4'h6,0,1,0);
    add(0,0,0,0,0, 4'h6,0,1,0); add(0,0,0,0,0, 4'h6,0,1,0);
    add(0,1,1,0,0, 4'h6,0,1,0); add(0,0,0,0,0, 4'h6,0,1,0);
    add(0,1,1,0,0, 4'hB,1,0,0); add(0,0,0,1,0, 4'hB,1,0,0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);

    // Vector table: one clock per row, outputs checked 1 time unit after the edge.
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      rst = v.rst; bus.en = v.en; bus.in = v.in; bus.flush = v.flush; bus.ack = v.ack;
      model_step(v.rst, v.en, v.in, v.flush);
      @(posedge clk); #1;
      check($sformatf("row%0d_out", k), 32'(bus.out), 32'(v.out));
      check($sformatf("row%0d_valid", k), 32'(bus.valid), 32'(v.valid));
      check($sformatf("row%0d_busy", k), 32'(bus.busy), 32'(v.busy));
      check($sformatf("row%0d_ovr", k), 32'(bus.overrun), 32'(v.ovr));
      sb_check();
    end
    rst = 1'b0; bus.en = 1'b0; bus.in = 1'b0; bus.flush = 1'b0; bus.ack = 1'b0;

    // Asynchronous reset mid-word with a pending word and overrun set.
    pulse_reset();
    send(1); send(0); send(0); send(1);
    send(0); send(1); send(1); send(0);
    check("pre_async_ovr", 32'(bus.overrun), 32'h1);
    send(1); send(1);
    check("pre_async_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("async_busy", 32'(bus.busy), 32'h0);
    check("async_valid", 32'(bus.valid), 32'h0);
    check("async_out", 32'(bus.out), 32'h0);
    check("async_ovr", 32'(bus.overrun), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(1); send(1); send(0); send(0);
    check("post_async_out", 32'(bus.out), 32'hC);
    check("post_async_ovr", 32'(bus.overrun), 32'h0);

    // MSB-first loopback from a parallel-in serial-out source.
    bus.ack = 1'b1; @(posedge clk); #1; bus.ack = 1'b0;
    p = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      send(p[3]);
      p = p << 1;
    end
    check("msb_loop_out", 32'(bus.out), 32'h9);

    // LSB-first receiver.
    send2(1); send2(0); send2(0);
    check("lsb_busy", 32'(bus2.busy), 32'h1);
    send2(0);
    check("lsb_out", 32'(bus2.out), 32'h1);
    check("lsb_valid", 32'(bus2.valid), 32'h1);
    bus2.ack = 1'b1; @(posedge clk); #1; bus2.ack = 1'b0;
    p = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      send2(p[0]);
      p = p >> 1;
    end
    check("lsb_loop_out", 32'(bus2.out), 32'h9);
    check("lsb_loop_ovr", 32'(bus2.overrun), 32'h0);

    check("sb_drained", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
